// File: rtl/int_trap_unit.sv
// int_trap_unit: machine-mode interrupt/trap unit.
// Holds mstatus.MIE/MPIE, mie, mtvec, mepc and mcause. Arbitrates the external,
// software and timer interrupts, requests a trap from the pipeline controller,
// and produces the one-cycle redirect for trap entry and for mret return.
// Optional build macro: VECTORED_MTVEC_EN (adds vectored mtvec mode 01).
module int_trap_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ext_irq,
    input  logic            sw_irq,
    input  logic            timer_irq,
    output logic            interrupt,
    input  logic            int_ack,
    input  logic [XLEN-1:0] epc_in,
    input  logic            mret_commit,
    input  logic            stall_pipl,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    typedef enum logic [1:0] {IDLE, PENDING, REDIRECT} state_e;

    state_e          state_q, state_d;
    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]      irq_en_q, irq_en_d;       // {ext, timer, sw} enables (mie bits 11/7/3)
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic            interrupt_q;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic [2:0]      irq_src;
    logic [2:0]      pend;
    logic            pend_any;
    logic [3:0]      cause_code;
    logic            trap_take;
    logic            mret_ok;
    logic            csr_wr_ok;
    logic [1:0]      mtvec_mode_wr;
    logic [XLEN-1:0] trap_target;
    logic            unused_epc_bits;

    // mepc is word aligned, so the low PC bits never get stored.
    assign unused_epc_bits = ^epc_in[1:0];

    assign irq_src  = {ext_irq, timer_irq, sw_irq};
    assign pend     = irq_src & irq_en_q & {3{mstatus_mie_q}};
    assign pend_any = |pend;

    // Fixed priority: external (11) over software (3) over timer (7).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cause_code = 4'd0;
        if (pend[2])      cause_code = 4'd11;
        else if (pend[0]) cause_code = 4'd3;
        else if (pend[1]) cause_code = 4'd7;
    end

    // A trap is accepted only while requesting and still holding a pending source.
    assign trap_take = (state_q == PENDING) && int_ack && !stall_pipl && pend_any;
    assign mret_ok   = mret_commit && !stall_pipl;
    // Trap/mret updates own mstatus, mepc and mcause in the cycle they happen.
    assign csr_wr_ok = csr_we && !(trap_take || mret_ok);

    // Trap vector: direct base, or base + 4*code in vectored mode.
    always_comb begin
        trap_target = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef VECTORED_MTVEC_EN
        if (mtvec_q[1:0] == 2'b01)
            trap_target = {mtvec_q[XLEN-1:2], 2'b00} + XLEN'({cause_code, 2'b00});
        mtvec_mode_wr = (csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00;
`else
        mtvec_mode_wr = 2'b00;
`endif
    end

    // CSR next state: software writes first, then mret and trap entry override.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        irq_en_d       = irq_en_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;

        if (csr_we) begin
            case (csr_addr)
                ADDR_MIE:   irq_en_d = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
                ADDR_MTVEC: mtvec_d  = {csr_wdata[XLEN-1:2], mtvec_mode_wr};
                default: ;
            endcase
        end
        if (csr_wr_ok) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = csr_wdata[3];
                    mstatus_mpie_d = csr_wdata[7];
                end
                ADDR_MEPC:   mepc_d   = {csr_wdata[XLEN-1:2], 2'b00};
                ADDR_MCAUSE: mcause_d = csr_wdata;
                default: ;
            endcase
        end

        if (mret_ok) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        // With a simultaneous mret, the trap stacks the MIE that mret just restored
        // and the return address stays the one already in mepc.
        if (trap_take) begin
            mstatus_mpie_d = mret_ok ? mstatus_mpie_q : mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mcause_d       = {1'b1, (XLEN-1)'(cause_code)};
            if (!mret_ok)
                mepc_d = {epc_in[XLEN-1:2], 2'b00};
        end
    end

    // Request FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (pend_any) state_d = PENDING;
            PENDING: begin
                if (trap_take)      state_d = REDIRECT;
                else if (!pend_any) state_d = IDLE;
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Redirect target: trap vector wins over mret return.
    always_comb begin
        redirect_pc_d = redirect_pc_q;
        if (trap_take)    redirect_pc_d = trap_target;
        else if (mret_ok) redirect_pc_d = mepc_q;
    end

    // State, CSR and registered output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            irq_en_q       <= '0;
            mtvec_q        <= MTVEC_RESET;
            mepc_q         <= '0;
            mcause_q       <= '0;
            interrupt_q    <= 1'b0;
            redirect_q     <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            irq_en_q       <= irq_en_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            interrupt_q    <= (state_d == PENDING);
            redirect_q     <= trap_take || mret_ok;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    assign interrupt   = interrupt_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

    // Combinational CSR read mux; unmapped addresses read zero.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                csr_rdata[3] = mstatus_mie_q;
                csr_rdata[7] = mstatus_mpie_q;
            end
            ADDR_MIE: begin
                csr_rdata[3]  = irq_en_q[0];
                csr_rdata[7]  = irq_en_q[1];
                csr_rdata[11] = irq_en_q[2];
            end
            ADDR_MTVEC:  csr_rdata = mtvec_q;
            ADDR_MEPC:   csr_rdata = mepc_q;
            ADDR_MCAUSE: csr_rdata = mcause_q;
            ADDR_MIP: begin
                csr_rdata[3]  = sw_irq;
                csr_rdata[7]  = timer_irq;
                csr_rdata[11] = ext_irq;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/int_trap_unit.md
Name: int_trap_unit

Overview:
Machine-mode interrupt/trap unit that drives the `interrupt` request into int_pipeline_controller and consumes that controller's commit-side responses (acknowledge, mret commit).
- Owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc and mcause.
- Arbitrates the three M-mode interrupt sources.
- Produces the redirect PC for trap entry and for mret return.
- Sits beside the CSR file; its CSR port is muxed into the core's CSR read/write path.

Parameters:
XLEN, 32, data/PC width
MTVEC_RESET, 32'h0000_0100, reset value of mtvec (mode bits 00)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-high reset
ext_irq  in  1  machine external interrupt, level
sw_irq  in  1  machine software interrupt, level
timer_irq  in  1  machine timer interrupt, level
interrupt  out  1  request to pipeline controller
int_ack  in  1  controller has flushed younger ops; trap taken this cycle
epc_in  in  XLEN  PC of the oldest un-committed instruction, valid with int_ack
mret_commit  in  1  mret reached commit (mret_type at MEM, not stalled)
stall_pipl  in  1  pipeline stall; qualifies int_ack and mret_commit
redirect  out  1  one-cycle PC redirect strobe
redirect_pc  out  XLEN  target for redirect
csr_we  in  1  CSR write strobe
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  CSR write data
csr_rdata  out  XLEN  combinational read data (0 for unmapped addresses)

Behaviour:
- Reset values:
  - interrupt=0, redirect=0, redirect_pc=0, state=IDLE.
  - MIE=0, MPIE=0, mie=0, mepc=0, mcause=0, mtvec=MTVEC_RESET.
- CSR map:
  - mstatus 0x300: bit3 MIE, bit7 MPIE; other bits read 0.
  - mie 0x304: bits 3/7/11.
  - mtvec 0x305.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: read-only, {ext_irq,0,0,0,timer_irq,0,0,0,sw_irq,0,0,0} at bits 11/7/3.
- Pending and priority:
  - pend = mip & mie & {MIE}.
  - Priority: ext (cause 11) > sw (3) > timer (7).
  - mcause value = {1'b1, (XLEN-1)'(code)}.
- FSM:
  - IDLE: if pend != 0 -> PENDING; interrupt rises the next cycle (registered).
  - PENDING: interrupt=1. If pend becomes 0 (source drops or CSR write clears MIE/mie) -> IDLE and interrupt=0 next cycle. If int_ack & !stall_pipl -> REDIRECT.
  - REDIRECT: redirect=1 for exactly one cycle, redirect_pc = trap target -> IDLE.
- Trap entry (on the accepted int_ack edge):
  - mepc <= epc_in.
  - mcause <= highest pend at that cycle.
  - MPIE <= MIE; MIE <= 0.
  - Latency: 1 cycle from ack to redirect.
- mret (mret_commit & !stall_pipl), in any state:
  - MIE <= MPIE; MPIE <= 1.
  - Next cycle: redirect=1, redirect_pc=mepc.
- Simultaneous events:
  - Ack and mret in the same cycle: mret applied first, then trap. mepc keeps its old value (epc_in ignored); MPIE <= restored MIE; MIE <= 0; redirect to trap target.
  - CSR write and trap/mret in the same cycle: the trap/mret update wins for mstatus, mepc and mcause.
- int_ack outside PENDING is ignored. Qualified ack/mret signals are ignored while stall_pipl=1.
- Trap target, direct mode: {mtvec[XLEN-1:2], 2'b00}.
- Reset mid-operation: all state returns to reset values immediately (async), with no redirect.

Optional Feature:
VECTORED_MTVEC_EN
- Defined:
  - mtvec[1:0] is writable; mode 01 = vectored.
  - Interrupt target = base + 4*cause_code (e.g. base+0x2C for ext).
  - Modes 10/11 are written as 00.
- Undefined:
  - mtvec[1:0] is hardwired 00 and writes to it are ignored.
  - Always direct mode.

Test Plan:
- Reset -> interrupt=0, redirect=0, csr_rdata@0x305=0x100, mstatus=0.
- Enable MIE and mie[11], raise ext_irq; ack with epc_in=0x2000 -> redirect=1 with redirect_pc=0x100 one cycle later; mepc=0x2000; mcause=0x8000000B; MIE=0, MPIE=1.
- ext, sw and timer raised together -> mcause=0x8000000B. Clear mie[11] and repeat -> mcause=0x80000003.
- In PENDING, deassert the source before ack -> interrupt drops next cycle, state=IDLE, mepc unchanged.
- In the handler, mret_commit with stall_pipl=1 for 2 cycles then 0 -> single redirect to 0x2000 only after the stall releases; MIE=1.
- With VECTORED_MTVEC_EN: write mtvec=0x201, take a timer interrupt -> redirect_pc=0x21C.
